sync_fifo_pro: RTL and testbench
================================

Name: sync_fifo_pro

Overview:
- Parametrised synchronous single-clock FIFO. Next generation of the team's basic sync FIFO.
- Adds true full/empty on all DEPTH entries, programmable almost_full/almost_empty, an occupancy count, synchronous flush, and registered sticky error flags.
- Used as the data buffer between the AXI4 DMA read-channel and write-channel engines.
- Storage is an internal register array; no external RAM instance.

Parameters:
- DW, 32, data width in bits (1..1024).
- DEPTH, 16, number of entries; must be a power of 2, at least 4.
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- Local AW = clog2(DEPTH). Count width is AW+1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous reset, active-low.
- clr  in  1  synchronous flush; wins over wr_en/rd_en.
- wr_en  in  1  write request.
- din  in  DW  write data.
- rd_en  in  1  read request.
- dout  out  DW  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was rejected.
- underflow  out  1  one-cycle pulse: a read was rejected.
- err_sticky  out  2  {ovf_seen, unf_seen}; cleared only by rstn or clr.

Behaviour:
- Reset (async assert, sync release) values:
  - wr_ptr, rd_ptr, count = 0
  - dout = 0
  - empty = 1, almost_empty = 1
  - full = 0, almost_full = 0
  - overflow = 0, underflow = 0, err_sticky = 0
  - Array contents are not reset.
- Flags are decoded from the registered count. They reflect state after the most recent edge; no look-ahead.
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0. Occupancy is tracked only by count; all DEPTH entries are usable.
- Write acceptance: wr_acc = wr_en & (!full | rd_acc).
  - A full FIFO accepts a write in the same cycle a read is accepted.
- Read acceptance: rd_acc = rd_en & !empty.
  - On an empty FIFO with rd_en & wr_en, the read is rejected (underflow pulses) and the write is accepted.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both accepted or neither
  - count never exceeds DEPTH and never goes below 0.
- overflow = registered (wr_en & !wr_acc). underflow = registered (rd_en & !rd_acc). Each sets its err_sticky bit in the same cycle.
- Standard read mode (macro absent):
  - dout loads mem[rd_ptr] on the edge where rd_acc = 1, so data appears 1 cycle after the read request.
  - dout holds its value otherwise, including on rejected reads.
- clr (synchronous):
  - pointers, count, overflow, underflow, err_sticky -> 0 at the next edge
  - concurrent wr_en/rd_en are ignored and raise no errors
  - dout holds its value.
- Write-to-read latency:
  - a word written at edge N makes empty = 0 after edge N
  - it can be read starting with the request in the next cycle.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - dout = mem[rd_ptr] combinationally; the head word is valid whenever empty = 0.
  - rd_en acts as a pop/acknowledge and advances rd_ptr.
  - A word written into an empty FIFO at edge N is on dout after edge N.
  - The dout register and its reset value do not exist; dout is don't-care while empty = 1.
- Undefined: standard read mode as above. Flags, count and error logic are identical in both modes.

Test Plan:
- Reset, then write 16 words 0x0..0xF with DEPTH=16 -> full = 1 and count = 16 after the 16th edge; almost_full first asserts after the 12th write; a 17th write gives overflow = 1 for one cycle, err_sticky = 2'b10, count stays 16.
- Continue from full: read 16 words -> dout = 0x0..0xF in order, each 1 cycle after its rd_en; empty = 1 after the last read; one extra read gives underflow pulse, err_sticky = 2'b11.
- At count = 16, assert rd_en & wr_en with din = 0xAA for one cycle -> no overflow, count stays 16, 0xAA is read last after the 15 remaining words.
- From empty, assert rd_en & wr_en with din = 0x55 -> underflow pulse, count = 1, next read returns 0x55.
- Write 5 words, pulse clr together with wr_en -> count = 0, empty = 1, err_sticky = 0, no overflow; then assert rstn low mid-burst -> all outputs take reset values immediately, without waiting for a clock edge.
- With SYNC_FIFO_FWFT_EN defined, write 0x11 then 0x22 -> dout = 0x11 after the first write edge with no rd_en; one rd_en -> dout = 0x22; second rd_en -> empty = 1.

Source files
------------

// File: rtl/sync_fifo_pro.sv
// sync_fifo_pro: single-clock FIFO with count, almost_full/almost_empty, sync flush and sticky error flags.
// Latency: standard mode returns dout 1 cycle after an accepted rd_en; SYNC_FIFO_FWFT_EN shows the head word combinationally.
// Backpressure: writes are rejected when full unless a read is accepted in the same cycle (overflow pulse); reads are rejected when empty (underflow pulse).
//
// Ports:
//   clk, rstn (async assert, active-low), clr (synchronous flush, wins over wr_en/rd_en)
//   wr_en/din write side, rd_en/dout read side
//   full, empty, almost_full, almost_empty, count : decoded from the registered occupancy
//   overflow, underflow : one-cycle pulses for rejected requests
//   err_sticky          : {ovf_seen, unf_seen}, cleared by rstn or clr
// Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_pro #(
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [DW-1:0]            din,
    input  logic                     rd_en,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    output logic [1:0]               err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          ovf_q,    ovf_d;
    logic          unf_q,    unf_d;
    logic [1:0]    sticky_q, sticky_d;
    logic          wr_acc;
    logic          rd_acc;

    // Flags come straight from the registered count: no look-ahead.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign err_sticky   = sticky_q;

    always_comb begin
        rd_acc   = 1'b0;
        wr_acc   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        sticky_d = sticky_q;

        if (clr) begin
            // Flush: requests in this cycle are dropped silently.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            sticky_d = 2'b00;
        end else begin
            rd_acc = rd_en & ~empty;
            // A full FIFO can still take a write when a read frees a slot this cycle.
            wr_acc = wr_en & (~full | rd_acc);

            if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            ovf_d    = wr_en & ~wr_acc;
            unf_d    = rd_en & ~rd_acc;
            sticky_d = sticky_q | {ovf_d, unf_d};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            sticky_q <= 2'b00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            sticky_q <= sticky_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; meaningless while empty.
    assign dout = mem_q[rd_ptr_q];
`else
    logic [DW-1:0] dout_q;

    // Loads only on an accepted read; holds across rejected reads and flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q <= '0;
        end else if (rd_acc) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_pro.sv
module tb_sync_fifo_pro;

    localparam int DW       = 32;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = 12;
    localparam int AE_LEVEL = 4;
    localparam int AW       = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic [1:0]    err_sticky;

    sync_fifo_pro #(
        .DW(DW), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk(clk), .rstn(rstn), .clr(clr),
        .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    // Expected post-edge state for one clock edge.
    typedef struct {
        int            cnt;
        logic          ovf;
        logic          unf;
        logic [1:0]    st;
        logic          dv;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mq[$];        // reference FIFO contents, head at index 0
    logic [1:0]    m_st = 2'b00;
    logic [DW-1:0] m_dout = '0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and predict the state after the next rising edge.
    task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        exp_t e;
        int   sz;
        bit   ra, wa;
        @(negedge clk);
        wr_en = w; din = d; rd_en = r; clr = c;
        sz = mq.size();
        ra = r && !c && (sz > 0);
        wa = w && !c && ((sz < DEPTH) || ra);
        if (c) begin
            mq.delete();
            m_st  = 2'b00;
            e.ovf = 1'b0;
            e.unf = 1'b0;
        end else begin
            if (ra) m_dout = mq.pop_front();
            if (wa) mq.push_back(d);
            e.ovf = w && !wa;
            e.unf = r && !ra;
            m_st  = m_st | {e.ovf, e.unf};
        end
        e.cnt = mq.size();
        e.st  = m_st;
`ifdef SYNC_FIFO_FWFT_EN
        e.dv = (mq.size() > 0);
        e.d  = e.dv ? mq[0] : '0;
`else
        e.dv = 1'b1;
        e.d  = m_dout;
`endif
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: compares DUT outputs after each edge against the queued prediction.
    exp_t me;
    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("count",        64'(count),        64'(me.cnt));
            chk("full",         64'(full),         64'(me.cnt == DEPTH));
            chk("empty",        64'(empty),        64'(me.cnt == 0));
            chk("almost_full",  64'(almost_full),  64'(me.cnt >= AF_LEVEL));
            chk("almost_empty", 64'(almost_empty), 64'(me.cnt <= AE_LEVEL));
            chk("overflow",     64'(overflow),     64'(me.ovf));
            chk("underflow",    64'(underflow),    64'(me.unf));
            chk("err_sticky",   64'(err_sticky),   64'(me.st));
            if (me.dv) chk("dout", 64'(dout), 64'(me.d));
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_count"},  64'(count),        64'(0));
        chk({tag, "_empty"},  64'(empty),        64'(1));
        chk({tag, "_aempty"}, 64'(almost_empty), 64'(1));
        chk({tag, "_full"},   64'(full),         64'(0));
        chk({tag, "_afull"},  64'(almost_full),  64'(0));
        chk({tag, "_ovf"},    64'(overflow),     64'(0));
        chk({tag, "_unf"},    64'(underflow),    64'(0));
        chk({tag, "_sticky"}, 64'(err_sticky),   64'(0));
`ifndef SYNC_FIFO_FWFT_EN
        chk({tag, "_dout"},   64'(dout),         64'(0));
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Fill 0x0..0xF, then one write too many.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, DW'(i), 1'b0, 1'b0);
        drive(1'b1, 32'h99, 1'b0, 1'b0);
        idle();

        // Drain in order, then one read too many.
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Simultaneous read/write while full: 0xAA must come out last.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b1, 32'hAA, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Simultaneous read/write while empty: read rejected, write kept.
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Head-word visibility directly after a write into an empty FIFO.
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 99) < 55), $urandom,
                  ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 2));
        end
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, '0, 1'b1, 1'b0);

        // Five writes, then flush together with a write.
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b1, 32'h77, 1'b0, 1'b1);
        idle();

        // Build up errors and occupancy, then async reset mid-burst.
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b1, 32'hC3, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        mq.delete();
        m_st = 2'b00;
        m_dout = '0;
        exp_q.delete();
        #1;
        chk_reset_outputs("async_rst");
        @(posedge clk);
        #2;
        chk_reset_outputs("rst_held");
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
        rstn = 1'b1;

        // Recovery after reset.
        drive(1'b1, 32'hE1, 1'b0, 1'b0);
        drive(1'b1, 32'hE2, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b0);
        idle();

        @(posedge clk);
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
